updown_counter_nbit: RTL and testbench

Parametrised up/down counter that generalises the single-bit `Increase`-driven counter to WIDTH bits, with an arbitrary terminal value, decrement, parallel load and a runtime wrap/saturate mode. It sits directly behind the user-input conditioning in the lab datapath and feeds occupancy and level values to the system state machine. Registered event pulses report every wrap or blocked step.

---
 rtl/updown_counter_nbit.sv | 100 ++++++++++
 tb/tb_updown_counter_nbit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/updown_counter_nbit.sv
// WIDTH-bit up/down counter: terminal value MAX_COUNT, parallel load, wrap/saturate mode, event pulses.
// Optional macro COUNTER_EDGE_DETECT_EN turns Increase/Decrease into rising-edge events.
module updown_counter_nbit #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = 15
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Increase,
  input  logic             Decrease,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             Mode,
  output logic [WIDTH-1:0] Count,
  output logic             AtMax,
  output logic             AtZero,
  output logic             Wrap,
  output logic             Blocked
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  logic             inc_ev;
  logic             dec_ev;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             blocked_nxt;

`ifdef COUNTER_EDGE_DETECT_EN
  logic inc_prev;
  logic dec_prev;

  // Previous-cycle samples; updated every cycle, load cycles included.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      inc_prev <= 1'b0;
      dec_prev <= 1'b0;
    end else begin
      inc_prev <= Increase;
      dec_prev <= Decrease;
    end
  end

  assign inc_ev = Increase & ~inc_prev;
  assign dec_ev = Decrease & ~dec_prev;
`else
  assign inc_ev = Increase;
  assign dec_ev = Decrease;
`endif

  // Next count and event pulses; terminal compare happens before the step.
  always_comb begin
    count_nxt   = Count;
    wrap_nxt    = 1'b0;
    blocked_nxt = 1'b0;
    if (Load) begin
      count_nxt = (LoadValue > MAX_VAL) ? MAX_VAL : LoadValue;
    end else if (inc_ev && dec_ev) begin
      count_nxt = Count;
    end else if (inc_ev) begin
      if (Count == MAX_VAL) begin
        if (Mode) begin
          blocked_nxt = 1'b1;
        end else begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end
      end else begin
        count_nxt = Count + WIDTH'(1);
      end
    end else if (dec_ev) begin
      if (Count == '0) begin
        if (Mode) begin
          blocked_nxt = 1'b1;
        end else begin
          count_nxt = MAX_VAL;
          wrap_nxt  = 1'b1;
        end
      end else begin
        count_nxt = Count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Count   <= '0;
      Wrap    <= 1'b0;
      Blocked <= 1'b0;
    end else begin
      Count   <= count_nxt;
      Wrap    <= wrap_nxt;
      Blocked <= blocked_nxt;
    end
  end

  assign AtMax  = (Count == MAX_VAL);
  assign AtZero = (Count == '0);

endmodule

// File: tb/tb_updown_counter_nbit.sv
// Scoreboard bench for updown_counter_nbit (WIDTH=4, MAX_COUNT=9): directed cases then random traffic.
module tb_updown_counter_nbit;
  localparam int unsigned WIDTH     = 4;
  localparam int unsigned MAX_COUNT = 9;

  typedef struct {
    int cnt;
    bit wrap;
    bit blocked;
  } exp_t;

  logic             Clock = 1'b0;
  logic             Reset = 1'b0;
  logic             Increase = 1'b0;
  logic             Decrease = 1'b0;
  logic             Load = 1'b0;
  logic [WIDTH-1:0] LoadValue = '0;
  logic             Mode = 1'b0;
  logic [WIDTH-1:0] Count;
  logic             AtMax;
  logic             AtZero;
  logic             Wrap;
  logic             Blocked;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  // reference model state
  int m_cnt = 0;
  bit m_prev_inc = 0;
  bit m_prev_dec = 0;

  updown_counter_nbit #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) dut (
    .Clock(Clock), .Reset(Reset), .Increase(Increase), .Decrease(Decrease),
    .Load(Load), .LoadValue(LoadValue), .Mode(Mode), .Count(Count),
    .AtMax(AtMax), .AtZero(AtZero), .Wrap(Wrap), .Blocked(Blocked)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected result.
  task automatic step(input bit inc, input bit dec, input bit ld, input int lv, input bit md);
    exp_t e;
    bit ev_inc, ev_dec;
    @(negedge Clock);
    Increase  = inc;
    Decrease  = dec;
    Load      = ld;
    LoadValue = WIDTH'(lv);
    Mode      = md;
`ifdef COUNTER_EDGE_DETECT_EN
    ev_inc = inc && !m_prev_inc;
    ev_dec = dec && !m_prev_dec;
`else
    ev_inc = inc;
    ev_dec = dec;
`endif
    e.wrap = 0;
    e.blocked = 0;
    if (ld) m_cnt = (lv > int'(MAX_COUNT)) ? int'(MAX_COUNT) : lv;
    else if (ev_inc && !ev_dec) begin
      if (m_cnt < int'(MAX_COUNT)) m_cnt++;
      else if (md) e.blocked = 1;
      else begin m_cnt = 0; e.wrap = 1; end
    end else if (ev_dec && !ev_inc) begin
      if (m_cnt > 0) m_cnt--;
      else if (md) e.blocked = 1;
      else begin m_cnt = int'(MAX_COUNT); e.wrap = 1; end
    end
    m_prev_inc = inc;
    m_prev_dec = dec;
    e.cnt = m_cnt;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input bit md);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, md);
  endtask

  // Asynchronous reset between edges, checked before the next edge.
  task automatic async_reset();
    @(negedge Clock);
    #2;
    Reset = 1'b0;
    Increase = 0; Decrease = 0; Load = 0;
    #1;
    check("async_rst_count", int'(Count), 0);
    check("async_rst_atzero", int'(AtZero), 1);
    check("async_rst_wrap", int'(Wrap), 0);
    check("async_rst_blocked", int'(Blocked), 0);
    m_cnt = 0; m_prev_inc = 0; m_prev_dec = 0;
    @(negedge Clock);
    Reset = 1'b1;
  endtask

  // Monitor: every rising edge with a pending expectation, compare all outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("count", int'(Count), e.cnt);
        check("wrap", int'(Wrap), int'(e.wrap));
        check("blocked", int'(Blocked), int'(e.blocked));
        check("atmax", int'(AtMax), int'(e.cnt == int'(MAX_COUNT)));
        check("atzero", int'(AtZero), int'(e.cnt == 0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    check("rst_count", int'(Count), 0);
    check("rst_atzero", int'(AtZero), 1);
    check("rst_atmax", int'(AtMax), 0);
    check("rst_wrap", int'(Wrap), 0);
    check("rst_blocked", int'(Blocked), 0);
    @(negedge Clock);
    Reset = 1'b1;

    // count up with wrap: 12 single-cycle pulses
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    // saturate down from 0
    step(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 1);
    end
    // saturate up at max, then wrap down from 0
    step(0, 0, 1, 9, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // load clamp beats increase, then simultaneous inc+dec holds
    step(1, 0, 1, 14, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // held increase for 5 cycles from 0
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // async reset at count 6, then one increase
    step(0, 0, 1, 6, 0);
    idle(1, 0);
    async_reset();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(bit'($urandom_range(0, 99) < 45), bit'($urandom_range(0, 99) < 40),
           bit'($urandom_range(0, 99) < 8), int'($urandom_range(0, 15)),
           bit'($urandom_range(0, 1)));
    end
    idle(2, 0);
    @(posedge Clock);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
